regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with a built-in scoreboard, the successor to the fixed 8×16, 2-read-port register file in the Rose datapath. It provides DATA_W-bit storage with NUM_RD registered read ports and one write port. Reads written in the same cycle return the new value (write-first bypass). A per-register pending bit lets the control unit reserve a destination register at issue and see on every read port whether the operand is still outstanding.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (≥1)
- ZERO_R0, 0, when 1 register 0 always reads 0, ignores writes and is never pending

- clk  in  1  single clock; all state updates on its rising edge
- clear  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (mark pending) the register at rsv_addr
- rsv_addr  in  ADDR_W  register to reserve
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered; bit i is the pending state of rd_addr[i]
- rsv_err  out  1  registered one-cycle pulse: the reservation hit an already-pending register
- pend_vec  out  2**ADDR_W  current pending bits (direct register output)

## Operation
- **Storage.** Array of 2**ADDR_W × DATA_W registers.
- **Write.** When wr_en is high, mem[wr_addr] ← wr_data and pend[wr_addr] ← 0.
- **Reserve.** When rsv_en is high, pend[rsv_addr] ← 1.
  - If the register was already pending, rsv_err pulses the next cycle. The reservation still takes effect.
- **Write and reserve to the same address in one cycle.** Data is written and pend ends at 1 (the new producer wins). rsv_err is evaluated on the pend value before the write, so it is 0 unless the register was already pending.
- **Read, per port i.**
  - rd_data[i] ← (wr_en && wr_addr==rd_addr[i]) ? wr_data : mem[rd_addr[i]].
  - rd_busy[i] ← the pending state of rd_addr[i] after this cycle's write/reserve updates.
- **ZERO_R0=1, address 0.**
  - Writes are ignored, with no bypass: a read returns 0.
  - Reservations are ignored: pend stays 0 and rsv_err stays 0.
  - rd_data is 0 and rd_busy is 0.
- **clear.** Synchronous and dominant over all other inputs in that cycle. On the next edge, every mem entry, pend, rd_data, rd_busy and rsv_err become 0; the write and reserve of that cycle are dropped.
- **Reset values.** All outputs are 0.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and data/busy are valid after edge N, stable until edge N+1.
- Write-first bypass has the same 1-cycle latency. A write at edge N is visible on rd_data after edge N.
- pend_vec reflects updates made at edge N immediately after edge N.
- rsv_err is a single-cycle pulse the cycle after the offending reservation. There is no stickiness.
- There is no handshake: the producer must hold rd_addr for as long as it needs the read result.
- Clear asserted mid-stream: pending reservations are lost. The control unit re-issues them after clear.

## Structure
- **Package regfile_pkg:**
  - default DATA_W/ADDR_W/NUM_RD constants;
  - a function returning the flat-bus slice for port i.
- **Sub-module regfile_scoreboard:**
  - owns the pend vector, the reserve/write update rule, rsv_err generation and the per-port busy lookup;
  - has its own clk/clear.
- **regfile_sb top:**
  - holds the data array and the read/bypass muxes (generate loop over NUM_RD);
  - instantiates the scoreboard.

## Test plan
- **Reset/basic (defaults):** clear for 1 cycle → rd_data=0 and rd_busy=0 on both ports. Write r3=0x1234, then read r3 on port 1 → 0x1234 one cycle later.
- **Bypass:** in one cycle, wr_en r5=0xBEEF with rd_addr0=5 and rd_addr1=5 → both ports 0xBEEF next cycle. A same-cycle read of r6 returns the old r6.
- **Scoreboard:** reserve r2 → pend_vec[2]=1 and rd_busy=1 for reads of r2. Then write r2=0x0042 → busy drops on the next read and data is 0x0042. Reserve r2 twice → rsv_err pulses once, after the second reservation.
- **Write+reserve same cycle:** wr r4 and rsv r4 together → r4 updated, pend[4]=1, rsv_err=0.
- **ZERO_R0=1, NUM_RD=3, DATA_W=32:**
  - write r0=0xFFFFFFFF and reserve r0 → all ports read 0, busy 0, no rsv_err;
  - r7 works normally on port 2.
- **Clear mid-operation:** reserve r1 and write r6=0x55 in the same cycle as clear → afterwards pend_vec=0, r6 reads 0 and rsv_err=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NUM_RD = 2;

    // Low bit of port `port` inside a flat bus of `width`-bit fields.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Write, reserve and read-port signals of the scoreboarded register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    // No handshake: every input is sampled on each rising edge, and the
    // read results are valid one cycle later. The requester holds rd_addr
    // for as long as it needs the result.
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;
    logic                       rsv_err;
    logic [(1<<ADDR_W)-1:0]     pend_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
        input  rd_data, rd_busy, rsv_err, pend_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
        output rd_data, rd_busy, rsv_err, pend_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reserve/write update, reservation error pulse
// and per-read-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     rsv_err,
    output logic [(1<<ADDR_W)-1:0]   pend_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [NUM_RD-1:0] busy_nxt;
    logic              err_nxt;
    logic              rsv_is_r0;

    assign rsv_is_r0 = (ZERO_R0 != 0) && (rsv_addr == '0);

    always_comb begin
        pend_nxt = pend;
        busy_nxt = '0;
        // Reserve is applied after the write so a same-cycle producer wins.
        if (wr_en) pend_nxt[wr_addr] = 1'b0;
        if (rsv_en) pend_nxt[rsv_addr] = 1'b1;
        if (ZERO_R0 != 0) pend_nxt[0] = 1'b0;
        err_nxt = rsv_en && pend[rsv_addr] && !rsv_is_r0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy_nxt[i] = pend_nxt[rd_addr[port_lo(i, ADDR_W) +: ADDR_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pend    <= '0;
            rd_busy <= '0;
            rsv_err <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            rd_busy <= busy_nxt;
            rsv_err <= err_nxt;
        end
    end

    assign pend_vec = pend;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-first registered read ports and a
// pending-bit scoreboard for operand tracking.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 0
) (
    input  logic       clk,
    input  logic       clear,
    regfile_sb_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wr_ok;
    logic [NUM_RD*DATA_W-1:0] rd_data_flat;

    // A write to a hard-wired zero register is dropped entirely, bypass included.
    assign wr_ok = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] q;

        assign ra = bus.rd_addr[port_lo(i, ADDR_W) +: ADDR_W];

        always_ff @(posedge clk) begin
            if (clear) begin
                q <= '0;
            end else if ((ZERO_R0 != 0) && (ra == '0)) begin
                q <= '0;
            end else if (wr_ok && (bus.wr_addr == ra)) begin
                q <= bus.wr_data;
            end else begin
                q <= mem[ra];
            end
        end

        assign rd_data_flat[port_lo(i, DATA_W) +: DATA_W] = q;
    end

    assign bus.rd_data = rd_data_flat;

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .clear    (clear),
        .wr_en    (wr_ok),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy),
        .rsv_err  (bus.rsv_err),
        .pend_vec (bus.pend_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance plus a ZERO_R0/3-port/32-bit
// instance, both checked every cycle against a behavioural model.
module tb_regfile_sb;

    logic clk;
    logic clear;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) ifa ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3)) ifb ();

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_R0(0)) u_a (
        .clk   (clk),
        .clear (clear),
        .bus   (ifa)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3), .ZERO_R0(1)) u_b (
        .clk   (clk),
        .clear (clear),
        .bus   (ifb)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model state ----------------
    logic [31:0] mem_m    [2][8];
    logic [7:0]  pend_m   [2];
    logic [31:0] exp_data [2][3];
    logic        exp_busy [2][3];
    logic        exp_err  [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // One clock edge of the register file, straight from its rules.
    task automatic model_step(input int k, input bit z, input int nrd,
                              input logic clr, input logic we, input logic [2:0] wa,
                              input logic [31:0] wd, input logic re,
                              input logic [2:0] rsa, input logic [8:0] rds);
        logic [7:0] p_old;
        logic       wr_ok;
        logic       rsv_ok;
        logic [2:0] a;
        if (clr) begin
            for (int j = 0; j < 8; j++) mem_m[k][j] = 32'h0;
            pend_m[k] = 8'h0;
            for (int i = 0; i < 3; i++) begin
                exp_data[k][i] = 32'h0;
                exp_busy[k][i] = 1'b0;
            end
            exp_err[k] = 1'b0;
            return;
        end
        p_old  = pend_m[k];
        wr_ok  = we && !(z && wa == 3'd0);
        rsv_ok = re && !(z && rsa == 3'd0);
        exp_err[k] = rsv_ok && p_old[rsa];
        for (int i = 0; i < nrd; i++) begin
            a = rds[i*3 +: 3];
            if (z && a == 3'd0)        exp_data[k][i] = 32'h0;
            else if (wr_ok && wa == a) exp_data[k][i] = wd;
            else                       exp_data[k][i] = mem_m[k][a];
        end
        if (wr_ok) begin
            mem_m[k][wa]  = wd;
            pend_m[k][wa] = 1'b0;
        end
        if (rsv_ok) pend_m[k][rsa] = 1'b1;
        for (int i = 0; i < nrd; i++) exp_busy[k][i] = pend_m[k][rds[i*3 +: 3]];
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        model_step(0, 1'b0, 2, clear, ifa.wr_en, ifa.wr_addr, {16'h0, ifa.wr_data},
                   ifa.rsv_en, ifa.rsv_addr, {3'b0, ifa.rd_addr});
        model_step(1, 1'b1, 3, clear, ifb.wr_en, ifb.wr_addr, ifb.wr_data,
                   ifb.rsv_en, ifb.rsv_addr, ifb.rd_addr);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("a_rd_data%0d", i), {16'h0, ifa.rd_data[i*16 +: 16]}, exp_data[0][i]);
            check($sformatf("a_rd_busy%0d", i), {31'h0, ifa.rd_busy[i]}, {31'h0, exp_busy[0][i]});
        end
        check("a_rsv_err", {31'h0, ifa.rsv_err}, {31'h0, exp_err[0]});
        check("a_pend_vec", {24'h0, ifa.pend_vec}, {24'h0, pend_m[0]});
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_rd_data%0d", i), ifb.rd_data[i*32 +: 32], exp_data[1][i]);
            check($sformatf("b_rd_busy%0d", i), {31'h0, ifb.rd_busy[i]}, {31'h0, exp_busy[1][i]});
        end
        check("b_rsv_err", {31'h0, ifb.rsv_err}, {31'h0, exp_err[1]});
        check("b_pend_vec", {24'h0, ifb.pend_vec}, {24'h0, pend_m[1]});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                           input logic re, input logic [2:0] ra, input logic [5:0] rds);
        ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd;
        ifa.rsv_en = re; ifa.rsv_addr = ra; ifa.rd_addr = rds;
    endtask

    task automatic drive_b(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                           input logic re, input logic [2:0] ra, input logic [8:0] rds);
        ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd;
        ifb.rsv_en = re; ifb.rsv_addr = ra; ifb.rd_addr = rds;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear = 1'b1;
        drive_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 6'h0);
        drive_b(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 9'h0);
        tick();
        check("lit_reset_a_data", {16'h0, ifa.rd_data[31:16]} | {16'h0, ifa.rd_data[15:0]}, 32'h0);
        check("lit_reset_a_busy", {30'h0, ifa.rd_busy}, 32'h0);

        clear = 1'b0;
        drive_a(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 6'h0);
        tick();
        drive_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, {3'd3, 3'd0});
        tick();
        check("lit_read_r3_p1", {16'h0, ifa.rd_data[31:16]}, 32'h1234);

        drive_a(1'b1, 3'd6, 16'h0666, 1'b0, 3'd0, 6'h0);
        tick();
        drive_a(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, {3'd5, 3'd5});
        tick();
        check("lit_bypass_p0", {16'h0, ifa.rd_data[15:0]}, 32'hBEEF);
        check("lit_bypass_p1", {16'h0, ifa.rd_data[31:16]}, 32'hBEEF);
        drive_a(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, {3'd5, 3'd6});
        tick();
        check("lit_old_r6", {16'h0, ifa.rd_data[15:0]}, 32'h0666);
        check("lit_bypass_r5", {16'h0, ifa.rd_data[31:16]}, 32'h1111);

        drive_a(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, {3'd0, 3'd2});
        tick();
        check("lit_pend2", {31'h0, ifa.pend_vec[2]}, 32'h1);
        check("lit_busy_r2", {31'h0, ifa.rd_busy[0]}, 32'h1);
        drive_a(1'b1, 3'd2, 16'h0042, 1'b0, 3'd0, {3'd0, 3'd2});
        tick();
        check("lit_unbusy_r2", {31'h0, ifa.rd_busy[0]}, 32'h0);
        check("lit_data_r2", {16'h0, ifa.rd_data[15:0]}, 32'h0042);
        drive_a(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 6'h0);
        tick();
        check("lit_err_first", {31'h0, ifa.rsv_err}, 32'h0);
        tick();
        check("lit_err_second", {31'h0, ifa.rsv_err}, 32'h1);
        drive_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 6'h0);
        tick();
        check("lit_err_pulse", {31'h0, ifa.rsv_err}, 32'h0);

        drive_a(1'b1, 3'd4, 16'hA5A5, 1'b1, 3'd4, {3'd0, 3'd4});
        tick();
        check("lit_wrsv_data", {16'h0, ifa.rd_data[15:0]}, 32'hA5A5);
        check("lit_wrsv_pend", {31'h0, ifa.pend_vec[4]}, 32'h1);
        check("lit_wrsv_err", {31'h0, ifa.rsv_err}, 32'h0);

        clear = 1'b1;
        drive_a(1'b1, 3'd6, 16'h0055, 1'b1, 3'd1, {3'd6, 3'd0});
        tick();
        clear = 1'b0;
        drive_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, {3'd6, 3'd0});
        tick();
        check("lit_clr_pend", {24'h0, ifa.pend_vec}, 32'h0);
        check("lit_clr_r6", {16'h0, ifa.rd_data[31:16]}, 32'h0);
        check("lit_clr_err", {31'h0, ifa.rsv_err}, 32'h0);

        drive_b(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1, 3'd0, 9'h0);
        tick();
        check("lit_b_r0_data", ifb.rd_data[31:0] | ifb.rd_data[63:32] | ifb.rd_data[95:64], 32'h0);
        check("lit_b_r0_busy", {29'h0, ifb.rd_busy}, 32'h0);
        drive_b(1'b1, 3'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, {3'd7, 3'd0, 3'd0});
        tick();
        check("lit_b_r0_err", {31'h0, ifb.rsv_err}, 32'h0);
        check("lit_b_r7_p2", ifb.rd_data[95:64], 32'hDEAD_BEEF);
        drive_b(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, {3'd7, 3'd0, 3'd0});
        tick();
        check("lit_b_r7_busy", {31'h0, ifb.rd_busy[2]}, 32'h1);

        for (int n = 0; n < 500; n++) begin
            clear = ($urandom_range(0, 59) == 0);
            drive_a(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
                    1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 6'($urandom()));
            drive_b(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                    1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 9'($urandom()));
            tick();
        end

        clear = 1'b0;
        drive_a(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 6'h0);
        drive_b(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 9'h0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
